// File: rtl/reset_generator_pkg.sv
// ---------------------------------------------------------------------------
// reset_generator_pkg
// Width helpers shared by the reset generator sources. State encodings stay
// local to the reset_generator module; only sizing arithmetic lives here.
// ---------------------------------------------------------------------------
package reset_generator_pkg;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Shared lock-filter / hold counter width.
   function automatic int cnt_width(input int lock_filter, input int hold_cycles);
      return $clog2(max_int(lock_filter, hold_cycles)) + 1;
   endfunction

   // Debounce counter must reach BUTTON_FILTER (one past the event count).
   function automatic int bcnt_width(input int button_filter);
      return $clog2(button_filter + 1) + 1;
   endfunction

endpackage

// File: rtl/reset_generator_sync.sv
// ---------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer for a single asynchronous bit. The flops have no
// reset so they can be packed tightly together as a synchronizer chain.
// Ports:
//   clk  in   destination clock
//   d    in   asynchronous input bit
//   q    out  synchronized bit, STAGES cycles behind d
// ---------------------------------------------------------------------------
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_r;

   always_ff @(posedge clk) begin
      sync_r <= {sync_r[STAGES-2:0], d};
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/reset_generator.sv
// ---------------------------------------------------------------------------
// reset_generator
// Builds the clk_1x-domain synchronous reset from PLL lock and the board
// reset button. Reset is released only after lock has been stable for
// LOCK_FILTER cycles followed by HOLD_CYCLES cycles; it re-asserts on loss
// of lock or on a debounced button press.
// Ports:
//   clk           in   clk_1x
//   reset         in   synchronous active-high; returns to S_WAIT_LOCK
//   pll_locked    in   asynchronous PLL lock
//   user_reset_n  in   asynchronous button, active-low
//   reset_out     out  registered system reset, active-high
//   reset_done    out  one-cycle pulse in the first cycle reset_out is low
//   lock_lost     out  sticky flag: lock dropped while running
// ---------------------------------------------------------------------------
module reset_generator
   import reset_generator_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int LOCK_FILTER   = 8,
   parameter int HOLD_CYCLES   = 16,
   parameter int BUTTON_FILTER = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic pll_locked,
   input  logic user_reset_n,
   output logic reset_out,
   output logic reset_done,
   output logic lock_lost
);

   localparam int CNT_W  = cnt_width(LOCK_FILTER, HOLD_CYCLES);
   localparam int BCNT_W = bcnt_width(BUTTON_FILTER);

   localparam logic [CNT_W-1:0]  LF_LAST  = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0]  HC_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [BCNT_W-1:0] BF_EVT   = BCNT_W'(BUTTON_FILTER - 1);
   localparam logic [BCNT_W-1:0] BF_PARK  = BCNT_W'(BUTTON_FILTER);

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_FILTER    = 2'd1,
      S_HOLD      = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               lost_set;

   logic               locked_s;
   logic               btn_raw;
   logic               btn_s;
   logic [BCNT_W-1:0]  bcnt;
   logic               btn_evt;

   // Button is active-low at the pin; synchronize the "pressed" sense.
   assign btn_raw = ~user_reset_n;

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk),
      .d   (pll_locked),
      .q   (locked_s)
   );

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_btn_sync (
      .clk (clk),
      .d   (btn_raw),
      .q   (btn_s)
   );

   // Debounce: btn_evt fires in the BUTTON_FILTER-th consecutive pressed
   // cycle. bcnt then parks one step past the event value, so a long press
   // produces exactly one event until the button is released.
   assign btn_evt = btn_s && (bcnt == BF_EVT);

   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt <= '0;
      end else if (!btn_s) begin
         bcnt <= '0;
      end else if (bcnt != BF_PARK) begin
         bcnt <= bcnt + BCNT_W'(1);
      end
   end

   // Next-state logic; priority is lock loss > button event > terminal count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lost_set  = 1'b0;
      case (state)
         S_WAIT_LOCK: begin
            cnt_nxt = '0;
            if (locked_s) state_nxt = S_FILTER;
         end
         S_FILTER: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (!locked_s) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == LF_LAST) begin
               state_nxt = S_HOLD;
               cnt_nxt   = '0;
            end
         end
         S_HOLD: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (!locked_s) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (btn_evt) begin
               cnt_nxt   = '0;
            end else if (cnt == HC_LAST) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
            end
         end
         S_RUN: begin
            cnt_nxt = '0;
            if (!locked_s) begin
               state_nxt = S_WAIT_LOCK;
               lost_set  = 1'b1;
            end else if (btn_evt) begin
               state_nxt = S_HOLD;
            end
         end
         default: begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so reset_out is a clean flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_WAIT_LOCK;
         cnt        <= '0;
         reset_out  <= 1'b1;
         reset_done <= 1'b0;
         lock_lost  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         reset_out  <= (state_nxt != S_RUN);
         reset_done <= (state_nxt == S_RUN) && (state != S_RUN);
         if (lost_set) lock_lost <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reset_generator.sv
module tb_reset_generator;

   localparam int SYNC = 2;
   localparam int LF   = 8;
   localparam int HC   = 16;
   localparam int BF   = 4;
   localparam int BIG  = 1000000;

   logic clk = 1'b0;
   logic reset;
   logic pll_locked;
   logic user_reset_n;
   logic reset_out;
   logic reset_done;
   logic lock_lost;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   reset_generator #(
      .SYNC_STAGES   (SYNC),
      .LOCK_FILTER   (LF),
      .HOLD_CYCLES   (HC),
      .BUTTON_FILTER (BF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pll_locked   (pll_locked),
      .user_reset_n (user_reset_n),
      .reset_out    (reset_out),
      .reset_done   (reset_done),
      .lock_lost    (lock_lost)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: release is a function of how long lock has been
   // continuously seen and how long ago the last honoured button event was.
   // ------------------------------------------------------------------
   logic hist_pl [SYNC];
   logic hist_bt [SYNC];
   int   streak, press_len, age;
   logic prev_run;
   logic exp_ro, exp_rd, exp_ll;
   bit   started = 1'b0;

   initial begin
      for (int i = 0; i < SYNC; i++) begin
         hist_pl[i] = 1'b0;
         hist_bt[i] = 1'b0;
      end
   end

   always @(negedge clk) begin
      logic ls, bs, be, eff, nrun;
      int   prev_streak;
      if (started) begin
         chk_bit("model_reset_out", reset_out, exp_ro);
         chk_bit("model_reset_done", reset_done, exp_rd);
         chk_bit("model_lock_lost", lock_lost, exp_ll);
      end
      ls = hist_pl[SYNC-1];
      bs = hist_bt[SYNC-1];
      if (reset) begin
         started   = 1'b1;
         streak    = 0;
         press_len = 0;
         age       = BIG;
         prev_run  = 1'b0;
         exp_ro    = 1'b1;
         exp_rd    = 1'b0;
         exp_ll    = 1'b0;
      end else if (started) begin
         prev_streak = streak;
         streak      = ls ? streak + 1 : 0;
         press_len   = bs ? press_len + 1 : 0;
         be          = (press_len == BF);
         // A button event only matters once the lock filter has passed.
         eff         = be && ls && (prev_streak >= LF + 1);
         if (eff) age = 0;
         else if (age < BIG) age = age + 1;
         nrun = (streak >= LF + HC + 1) && (age >= HC);
         if (!ls && prev_run) exp_ll = 1'b1;
         exp_ro   = !nrun;
         exp_rd   = nrun && !prev_run;
         prev_run = nrun;
      end
      for (int i = SYNC - 1; i > 0; i--) begin
         hist_pl[i] = hist_pl[i-1];
         hist_bt[i] = hist_bt[i-1];
      end
      hist_pl[0] = pll_locked;
      hist_bt[0] = ~user_reset_n;
   end

   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Stimulus with hand-computed literal expectations
   // ------------------------------------------------------------------
   initial begin
      int hi_cnt, done_cnt, press_left;
      reset        = 1'b1;
      pll_locked   = 1'b0;
      user_reset_n = 1'b1;

      // Power-up: lock at cycle 10, release at cycle 37.
      wait_cyc(3);
      @(negedge clk);
      chk_bit("rst_reset_out", reset_out, 1'b1);
      chk_bit("rst_reset_done", reset_done, 1'b0);
      chk_bit("rst_lock_lost", lock_lost, 1'b0);
      wait_cyc(5);  reset = 1'b0;
      wait_cyc(10); pll_locked = 1'b1;
      wait_cyc(36); @(negedge clk);
      chk_bit("pwrup_hold_36", reset_out, 1'b1);
      chk_bit("pwrup_nodone_36", reset_done, 1'b0);
      wait_cyc(37); @(negedge clk);
      chk_bit("pwrup_release_37", reset_out, 1'b0);
      chk_bit("pwrup_done_37", reset_done, 1'b1);
      wait_cyc(38); @(negedge clk);
      chk_bit("pwrup_done_once_38", reset_done, 1'b0);

      // Short press (3 cycles) must be ignored.
      wait_cyc(50); user_reset_n = 1'b0;
      wait_cyc(53); user_reset_n = 1'b1;
      wait_cyc(60); @(negedge clk);
      chk_bit("short_press_ignored", reset_out, 1'b0);

      // Long press: one event, 16 cycles of reset, one reset_done.
      hi_cnt = 0; done_cnt = 0;
      for (int c = 70; c < 120; c++) begin
         wait_cyc(c);
         user_reset_n = (c < 80) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (reset_out)  hi_cnt++;
         if (reset_done) done_cnt++;
      end
      chk_int("btn_hold_len", hi_cnt, HC);
      chk_int("btn_done_count", done_cnt, 1);

      // Lock loss in run: reset_out/lock_lost three cycles after the drop.
      wait_cyc(130); pll_locked = 1'b0;
      wait_cyc(132); @(negedge clk);
      chk_bit("loss_still_run_132", reset_out, 1'b0);
      wait_cyc(133); @(negedge clk);
      chk_bit("loss_reset_133", reset_out, 1'b1);
      chk_bit("loss_flag_133", lock_lost, 1'b1);
      wait_cyc(140); pll_locked = 1'b1;
      wait_cyc(166); @(negedge clk);
      chk_bit("relock_hold_166", reset_out, 1'b1);
      wait_cyc(167); @(negedge clk);
      chk_bit("relock_release_167", reset_out, 1'b0);
      chk_bit("lock_lost_sticky", lock_lost, 1'b1);

      // Lock glitch: high 5, low 1, high; release 25 after the second rise.
      wait_cyc(180); reset = 1'b1; pll_locked = 1'b0;
      wait_cyc(183); reset = 1'b0;
      wait_cyc(190); pll_locked = 1'b1;
      wait_cyc(195); pll_locked = 1'b0;
      wait_cyc(196); pll_locked = 1'b1;
      wait_cyc(222); @(negedge clk);
      chk_bit("glitch_hold_222", reset_out, 1'b1);
      wait_cyc(223); @(negedge clk);
      chk_bit("glitch_release_223", reset_out, 1'b0);

      // Button event in hold at cnt=10 restarts the hold window.
      wait_cyc(230); reset = 1'b1; pll_locked = 1'b0;
      wait_cyc(233); reset = 1'b0;
      wait_cyc(240); pll_locked = 1'b1;
      wait_cyc(256); user_reset_n = 1'b0;
      wait_cyc(262); user_reset_n = 1'b1;
      wait_cyc(277); @(negedge clk);
      chk_bit("hold_restart_277", reset_out, 1'b1);
      wait_cyc(278); @(negedge clk);
      chk_bit("hold_restart_278", reset_out, 1'b0);
      chk_bit("hold_restart_done", reset_done, 1'b1);

      // Button event and lock loss in the same run cycle: lock loss wins.
      wait_cyc(300); user_reset_n = 1'b0;
      wait_cyc(303); pll_locked = 1'b0;
      wait_cyc(306); @(negedge clk);
      chk_bit("simul_reset", reset_out, 1'b1);
      chk_bit("simul_lost", lock_lost, 1'b1);
      wait_cyc(308); user_reset_n = 1'b1;
      wait_cyc(310); pll_locked = 1'b1;

      // Reset during hold clears lock_lost on the next cycle.
      wait_cyc(325); reset = 1'b1;
      wait_cyc(326); reset = 1'b0;
      @(negedge clk);
      chk_bit("rst_in_hold_lost", lock_lost, 1'b0);
      chk_bit("rst_in_hold_ro", reset_out, 1'b1);
      wait_cyc(351); @(negedge clk);
      chk_bit("rst_in_hold_release", reset_out, 1'b0);

      // Randomized traffic, checked by the model every cycle.
      press_left = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         reset = ($urandom_range(0, 999) < 3);
         if (pll_locked) begin
            if ($urandom_range(0, 99) < 1) pll_locked = 1'b0;
         end else begin
            if ($urandom_range(0, 99) < 20) pll_locked = 1'b1;
         end
         if (press_left > 0) begin
            press_left--;
            user_reset_n = (press_left == 0);
         end else if ($urandom_range(0, 99) < 3) begin
            press_left   = $urandom_range(1, 10);
            user_reset_n = 1'b0;
         end
      end
      reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
